// File: rtl/sprite_compositor_pkg.sv
// Shared constants for the sprite path.
// Holds the sprite memory address width, pixel width, colour key, background
// colour and sprite-sheet width. The per-object address generators use the
// same package, so these values must stay consistent across that path.
package sprite_compositor_pkg;

    localparam int ADDR_W  = 17;
    localparam int PIX_W   = 12;
    localparam int SHEET_W = 320;

    localparam logic [PIX_W-1:0] KEY_RGB = 12'hF0F;
    localparam logic [PIX_W-1:0] BG_RGB  = 12'h000;

endpackage

// File: rtl/obj_priority_mux.sv
// Combinational fixed-priority selector over the object request inputs.
// Index 0 has the highest priority.
// Ports:
//   obj_en   : per-object hit flags
//   obj_addr : packed per-object addresses, object i at [i*ADDR_W +: ADDR_W]
//   sel_hit  : at least one object is requesting
//   sel_addr : address of the winning object, 0 when nothing hits
module obj_priority_mux #(
    parameter int N_OBJ  = 4,
    parameter int ADDR_W = sprite_compositor_pkg::ADDR_W
) (
    input  logic [N_OBJ-1:0]        obj_en,
    input  logic [N_OBJ*ADDR_W-1:0] obj_addr,
    output logic                    sel_hit,
    output logic [ADDR_W-1:0]       sel_addr
);

    // Scan from the lowest priority upward so the lowest set index wins.
    always_comb begin
        sel_hit  = 1'b0;
        sel_addr = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (obj_en[i]) begin
                sel_hit  = 1'b1;
                sel_addr = obj_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Sprite pixel compositor.
// Selects the highest-priority active object, reads its pixel from the
// external synchronous sprite ROM, applies colour-key transparency and
// registers the 12-bit RGB output. The VGA syncs and valid flag travel with
// the pixel, so colour and sync always line up at the output.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   pclk_en         : pixel strobe, the pipeline advances only when high
//   valid_in        : active-video flag
//   hsync_in/vsync_in : active-low syncs
//   obj_en/obj_addr : per-object hit flags and packed addresses
//   mem_addr        : sprite ROM read address
//   mem_data        : sprite ROM read data, one clk of latency
//   vga_rgb         : {R,G,B} 4 bits each
//   hsync_out/vsync_out/valid_out : syncs and valid aligned to vga_rgb
module sprite_compositor #(
    parameter int                N_OBJ   = 4,
    parameter int                ADDR_W  = sprite_compositor_pkg::ADDR_W,
    parameter logic [11:0]       KEY_RGB = sprite_compositor_pkg::KEY_RGB,
    parameter logic [11:0]       BG_RGB  = sprite_compositor_pkg::BG_RGB
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pclk_en,
    input  logic                    valid_in,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic [N_OBJ-1:0]        obj_en,
    input  logic [N_OBJ*ADDR_W-1:0] obj_addr,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [11:0]             mem_data,
    output logic [11:0]             vga_rgb,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic                    valid_out
);

    import sprite_compositor_pkg::*;

    logic              sel_hit;
    logic [ADDR_W-1:0] sel_addr;

    logic              hit_p0, vld_p0, hs_p0, vs_p0;
    logic              hit_p1, vld_p1, hs_p1, vs_p1;
    logic [PIX_W-1:0]  pix_p1;
    logic              strb_d1;
    logic [PIX_W-1:0]  rom_pix;

    function automatic logic [PIX_W-1:0] resolve_pix(
        input logic             vld,
        input logic             hit,
        input logic [PIX_W-1:0] pix
    );
        if (!vld)
            return '0;
        else if (!hit || pix == KEY_RGB)
            return BG_RGB;
        else
            return pix;
    endfunction

    // Outside active video the object requests are meaningless; gate them off.
    obj_priority_mux #(
        .N_OBJ  (N_OBJ),
        .ADDR_W (ADDR_W)
    ) u_mux (
        .obj_en   (obj_en & {N_OBJ{valid_in}}),
        .obj_addr (obj_addr),
        .sel_hit  (sel_hit),
        .sel_addr (sel_addr)
    );

    // The ROM samples mem_addr on every clk edge, so on the edge right after
    // a strobe its output belongs to the pixel that strobe moved into S1.
    // pix_p1 captures it there and holds it across strobe gaps. When strobes
    // are back to back, the S2 load happens on that same edge, so the ROM
    // output is used directly instead of the not-yet-updated pix_p1.
    assign rom_pix = strb_d1 ? mem_data : pix_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_p0    <= 1'b0;
            vld_p0    <= 1'b0;
            hs_p0     <= 1'b1;
            vs_p0     <= 1'b1;
            mem_addr  <= '0;
            hit_p1    <= 1'b0;
            vld_p1    <= 1'b0;
            hs_p1     <= 1'b1;
            vs_p1     <= 1'b1;
            pix_p1    <= '0;
            strb_d1   <= 1'b0;
            vga_rgb   <= '0;
            valid_out <= 1'b0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            strb_d1 <= pclk_en;
            if (strb_d1)
                pix_p1 <= mem_data;
            if (pclk_en) begin
                // S0: select
                hit_p0    <= sel_hit;
                mem_addr  <= sel_addr;
                vld_p0    <= valid_in;
                hs_p0     <= hsync_in;
                vs_p0     <= vsync_in;
                // S1: fetch
                hit_p1    <= hit_p0;
                vld_p1    <= vld_p0;
                hs_p1     <= hs_p0;
                vs_p1     <= vs_p0;
                // S2: resolve
                vga_rgb   <= resolve_pix(vld_p1, hit_p1, rom_pix);
                valid_out <= vld_p1;
                hsync_out <= hs_p1;
                vsync_out <= vs_p1;
            end
        end
    end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Pixel compositor that sits directly downstream of the per-object sprite address generators. Each cycle it takes every object's `en`/`addr` pair for the current VGA coordinate, selects the highest-priority active object, reads its pixel from the shared 320-wide sprite block memory, applies colour-key transparency, and drives the registered 12-bit RGB output. The VGA sync and valid signals are delayed to stay aligned with the pixel.

## Interface
- `N_OBJ`, 4: number of object request inputs. Index 0 has the highest priority.
- `ADDR_W`, 17: sprite memory address width.
- `KEY_RGB`, 12'hF0F: colour-key value. Pixels equal to this value are transparent.
- `BG_RGB`, 12'h000: background colour.

- `clk`  in  1  system clock
- `rst`  in  1  reset. Asynchronous, active-high.
- `pclk_en`  in  1  pixel strobe. The pipeline advances only on cycles where it is 1.
- `valid_in`  in  1  active-video flag from the VGA controller
- `hsync_in`, `vsync_in`  in  1 each  syncs from the VGA controller. Active-low.
- `obj_en`  in  N_OBJ  per-object hit flags
- `obj_addr`  in  N_OBJ*ADDR_W  per-object addresses. Object i occupies bits [i*ADDR_W +: ADDR_W].
- `mem_addr`  out  ADDR_W  block memory read address
- `mem_data`  in  12  block memory read data. Synchronous ROM, 1-cycle latency, fed by `clk`.
- `vga_rgb`  out  12  {R[3:0], G[3:0], B[3:0]}
- `hsync_out`, `vsync_out`, `valid_out`  out  1 each  delayed copies of the inputs

## Operation
- The pipeline has 3 stages. All registers are updated only when `pclk_en` = 1, otherwise they hold.
  - **S0, select:** the priority encoder picks the lowest index i with `obj_en[i]` = 1. It registers `hit0`, `mem_addr` = `obj_addr[i]`, and `valid0`, `hs0`, `vs0`. With no hit, `hit0` = 0 and `mem_addr` = 0.
  - **S1, fetch:** the ROM returns data for `mem_addr`. The stage registers `hit1`, `valid1`, `hs1`, `vs1`. It also latches `mem_data` into `pix1` at the same strobe as the S2 load, so `pix1` is stable across pixel-enable gaps.
  - **S2, resolve:**
    - `valid1` = 0: `vga_rgb` = 0 (blanking).
    - `valid1` = 1, `hit1` = 0: `vga_rgb` = `BG_RGB`.
    - `valid1` = 1, `hit1` = 1, `pix1` = `KEY_RGB`: `vga_rgb` = `BG_RGB`. Lower-priority objects are NOT consulted.
    - Otherwise `vga_rgb` = `pix1`.
  - S2 also forwards `hsync_out`, `vsync_out`, `valid_out`.
- `obj_en` and `obj_addr` are ignored when `valid_in` = 0. This forces `hit0` = 0.
- The block performs no address arithmetic. Addresses pass through unchanged, with no wrap or clamp.

## Timing
- Reset, asynchronous, applied immediately:
  - `vga_rgb` = 0, `valid_out` = 0, `mem_addr` = 0.
  - `hsync_out` = `vsync_out` = 1 (inactive).
  - All internal hit/valid bits = 0, internal syncs = 1.
- Latency is exactly 3 `pclk_en` strobes from input sample to `vga_rgb`/sync/valid out. Sync and colour are always aligned.
- `mem_addr` changes only on strobes. The ROM sees a stable address for at least one full `clk` cycle before `pix1` is latched on the next strobe. This holds for `pclk_en` duty cycles from 1/1 to 1/4.
- `pclk_en` held at 0 freezes all outputs.
- Reset asserted mid-frame returns all outputs to reset values within the same cycle. After release, the first valid pixel appears 3 strobes after the first sampled `valid_in` = 1.
- Simultaneous hits resolve to the lowest index only.

## Structure
- Shared package/header holds `ADDR_W`, `PIX_W` (12), `KEY_RGB`, `BG_RGB`, and the sprite-sheet width constant 320, reused by the object modules.
- One sub-module, `obj_priority_mux`. It is purely combinational, parameterised by `N_OBJ`, and outputs `{hit, addr}`.
- The ROM is instantiated outside this block.

## Test plan
- **Single object:** `valid_in` = 1, `obj_en` = 4'b0100, addr2 = 17'd341, ROM[341] = 12'h3A7, `pclk_en` = 1 every cycle. Expect `mem_addr` = 341 after 1 strobe and `vga_rgb` = 12'h3A7 after 3 strobes.
- **Priority:** `obj_en` = 4'b0110, addr1 = 100, addr2 = 200. Expect `mem_addr` = 100 and output = ROM[100].
- **Transparency:** ROM[100] = 12'hF0F with obj1 hit. Expect `vga_rgb` = `BG_RGB` (12'h000).
- **Blanking and alignment:**
  - Drive `valid_in` = 0 with `obj_en` = 4'b1111. Expect `vga_rgb` = 0 and `mem_addr` = 0.
  - Drive an `hsync_in` low pulse. Expect `hsync_out` to go low exactly 3 strobes later, together with `valid_out`.
- **Pixel-enable gaps:** `pclk_en` = 1 every 4th cycle with a 4-pixel pattern. Expect outputs to change only on strobe cycles and to match the pattern delayed by 3 strobes.
- **Async reset mid-line:** assert `rst` between clock edges during active pixels. Expect outputs at reset values immediately, and recovery 3 strobes after release.
